memarb: RTL and testbench
=========================

# memarb

Two-requester arbiter that shares one port of the `mem` block between two masters, e.g. the core's data side (`stg_ma`/`stg_mo`) and a loader/debug master. It grants one request per cycle with round-robin fairness and bounded burst ownership. It muxes the granted request onto the memory port and routes the synchronous read data back to the requester that issued the read, tagged with a one-cycle valid.

## Interface

Parameters:
- `MAX_HOLD`, default 4: maximum consecutive grants to one requester while the other is waiting. Legal range 1..15.
- `PRIO`, default 0: requester that wins the first contended arbitration after reset.

Ports:
- `iw_clk`  in  1  the single clock; all state changes on its rising edge.
- `iw_rst_n`  in  1  reset; asynchronous, active-low.
- `iw_req0` / `iw_req1`  in  1  request valid; held with its payload stable until granted.
- `iw_we0` / `iw_we1`  in  1  1 = write, 0 = read.
- `iw_addr0` / `iw_addr1`  in  `SIZE_ADDR`  word address.
- `iw_wdata0` / `iw_wdata1`  in  `SIZE_DATA`  write data.
- `ow_gnt0` / `ow_gnt1`  out  1  combinational grant; the request is accepted in a cycle where req & gnt.
- `or_rvalid0` / `or_rvalid1`  out  1  registered; read data valid for that requester this cycle.
- `ow_rdata0` / `ow_rdata1`  out  `SIZE_DATA`  equals `iw_mem_rdata` when the matching rvalid is 1, otherwise 0.
- `ow_mem_we`  out  1  memory write enable.
- `ow_mem_addr`  out  `SIZE_ADDR`  memory address.
- `ow_mem_wdata`  out  `SIZE_DATA`  memory write data.
- `iw_mem_rdata`  in  `SIZE_DATA`  memory read data, valid one cycle after the address.
- `or_owner`  out  2  registered state: 00 = IDLE, 01 = OWN0, 10 = OWN1.

## Operation

State:
- FSM states are IDLE, OWN0 and OWN1.
- `r_hold` is a 4-bit count of consecutive grants to the current owner.
- `r_last` holds the id of the most recent owner.
- The read tracker is `r_rd_pend` plus `r_rd_id`.

Grant decision (combinational, evaluated every cycle):
- In OWNk, if `req_k` is set and either `r_hold < MAX_HOLD` or `req_other` = 0, grant k.
- Otherwise in OWNk, if `req_other` is set, grant the other requester.
- In IDLE, if exactly one requester is active, grant it. If both are active, grant `~r_last`.
- If no request is active, grant nothing.
- At most one of `ow_gnt0` and `ow_gnt1` is ever high.

Next state:
- A grant to g moves the FSM to OWNg and sets `r_last <= g`.
  - If g equals the previous owner, `r_hold <= min(r_hold+1, MAX_HOLD)` (saturating).
  - If g differs, `r_hold <= 1`.
- No grant moves the FSM to IDLE and sets `r_hold <= 0`. `r_last` is retained.

Memory port:
- Driven combinationally from the granted requester's we, addr and wdata.
- With no grant: `ow_mem_we=0`, `ow_mem_addr=0`, `ow_mem_wdata=0`.

Reads:
- An accepted read sets `r_rd_pend <= 1` and `r_rd_id <= g`. Any other cycle sets `r_rd_pend <= 0`.
- The cycle after acceptance, `or_rvalid[r_rd_id] = 1` for exactly one cycle and the matching rdata equals `iw_mem_rdata`.
- Reads are fully pipelined: back-to-back reads produce back-to-back rvalids, possibly to alternating requesters.

Writes:
- Take effect at the clock edge ending the acceptance cycle.
- Produce no response.
- A write followed by a read of the same address returns the new data.

Reset (asserted at any time, including mid-operation):
- State IDLE, `r_hold=0`, `r_last=~PRIO`, `r_rd_pend=0`, and all rvalid outputs 0.
- A read accepted in the cycle before reset assertion never returns; its response is dropped.
- Outputs while in reset:
  - gnt = 0 regardless of req.
  - mem port = 0.
  - rdata = 0.
  - `or_owner` = 00.

## Timing

- Grant has zero latency: the path runs req -> gnt -> mem port within one cycle, with no added register.
- Read latency is 1 cycle from acceptance to rvalid. Throughput is 1 access per cycle.
- A requester that loses arbitration waits at most `MAX_HOLD` cycles for a grant.
- Simultaneous assertion of both requests:
  - From IDLE, resolved by `r_last`.
  - From OWNk, resolved by the hold rule.
- Deasserting req without a grant is illegal; behaviour is undefined and is not checked.

## Test plan

- Reset: hold `iw_rst_n` = 0 with both reqs = 1.
  - Required during reset: gnts 0, rvalids 0, mem port 0, `or_owner` = 00.
  - After release, with `PRIO=0`: `ow_gnt0` = 1 in the first cycle.
- Single read: req0 reads addr 0x10, and the memory returns 0xABCD the next cycle.
  - Required: gnt0 = 1 and `ow_mem_addr` = 0x10 in cycle n.
  - Required in cycle n+1: `or_rvalid0` = 1, `ow_rdata0` = 0xABCD, `or_rvalid1` = 0.
- Contention (`MAX_HOLD=4`): both reqs held high for 12 cycles starting from IDLE.
  - Required grant sequence: 0,0,0,0,1,1,1,1,0,0,0,0.
  - `r_hold` never exceeds 4.
- Saturation: req1 alone for 10 cycles, then req0 also asserts.
  - Required: gnt1 on all 10 cycles.
  - The cycle req0 asserts, gnt0 = 1 immediately, because hold is saturated at 4.
- Round-robin from IDLE: req1 alone, then one idle cycle, then both reqs.
  - Required: gnt0 wins, because `r_last` = 1.
  - Repeating the sequence with req0 alone first makes gnt1 win.
- Mixed traffic and reset:
  - Write 0x5A5A to 0x20 via req1, then read 0x20 via req0 in the next cycle. Required: `or_rvalid0` = 1 with `ow_rdata0` = 0x5A5A.
  - Then accept a read and assert `iw_rst_n` = 0 before the next edge. Required: no rvalid ever appears for that read.

Source files
------------

// File: rtl/memarb.sv
// memarb: two-requester arbiter sharing one synchronous memory port.
// Round-robin with bounded burst ownership; read data is routed back to the requester that issued the read.
module memarb #(
    parameter int SIZE_ADDR = 16,
    parameter int SIZE_DATA = 16,
    parameter int MAX_HOLD  = 4,
    parameter bit PRIO      = 1'b0
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    input  logic                 iw_req0,
    input  logic                 iw_req1,
    input  logic                 iw_we0,
    input  logic                 iw_we1,
    input  logic [SIZE_ADDR-1:0] iw_addr0,
    input  logic [SIZE_ADDR-1:0] iw_addr1,
    input  logic [SIZE_DATA-1:0] iw_wdata0,
    input  logic [SIZE_DATA-1:0] iw_wdata1,
    output logic                 ow_gnt0,
    output logic                 ow_gnt1,
    output logic                 or_rvalid0,
    output logic                 or_rvalid1,
    output logic [SIZE_DATA-1:0] ow_rdata0,
    output logic [SIZE_DATA-1:0] ow_rdata1,
    output logic                 ow_mem_we,
    output logic [SIZE_ADDR-1:0] ow_mem_addr,
    output logic [SIZE_DATA-1:0] ow_mem_wdata,
    input  logic [SIZE_DATA-1:0] iw_mem_rdata,
    output logic [1:0]           or_owner
);

    // state | meaning
    // IDLE  | nothing was granted last cycle
    // OWN0  | requester 0 was granted last cycle
    // OWN1  | requester 1 was granted last cycle
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_hold;
    logic [3:0] w_hold_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       r_rd_pend;
    logic       r_rd_id;
    logic       w_gnt0;
    logic       w_gnt1;

    // Grant is gated by reset so nothing reaches the memory while rst_n is low.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            OWN0: begin
                if (iw_req0 && ((r_hold < HOLD_MAX) || !iw_req1))
                    w_gnt0 = 1'b1;
                else if (iw_req1)
                    w_gnt1 = 1'b1;
            end
            OWN1: begin
                if (iw_req1 && ((r_hold < HOLD_MAX) || !iw_req0))
                    w_gnt1 = 1'b1;
                else if (iw_req0)
                    w_gnt0 = 1'b1;
            end
            default: begin
                if (iw_req0 && iw_req1) begin
                    w_gnt0 = r_last;
                    w_gnt1 = ~r_last;
                end else begin
                    w_gnt0 = iw_req0;
                    w_gnt1 = iw_req1;
                end
            end
        endcase
        if (!iw_rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_hold_nxt  = 4'd0;
        w_last_nxt  = r_last;
        if (w_gnt0) begin
            w_state_nxt = OWN0;
            w_last_nxt  = 1'b0;
            if (r_state == OWN0)
                w_hold_nxt = (r_hold < HOLD_MAX) ? r_hold + 4'd1 : HOLD_MAX;
            else
                w_hold_nxt = 4'd1;
        end else if (w_gnt1) begin
            w_state_nxt = OWN1;
            w_last_nxt  = 1'b1;
            if (r_state == OWN1)
                w_hold_nxt = (r_hold < HOLD_MAX) ? r_hold + 4'd1 : HOLD_MAX;
            else
                w_hold_nxt = 4'd1;
        end
    end

    always_comb begin
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (w_gnt0) begin
            ow_mem_we    = iw_we0;
            ow_mem_addr  = iw_addr0;
            ow_mem_wdata = iw_wdata0;
        end else if (w_gnt1) begin
            ow_mem_we    = iw_we1;
            ow_mem_addr  = iw_addr1;
            ow_mem_wdata = iw_wdata1;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state   <= IDLE;
            r_hold    <= 4'd0;
            r_last    <= ~PRIO;
            r_rd_pend <= 1'b0;
            r_rd_id   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_last    <= w_last_nxt;
            r_rd_pend <= (w_gnt0 || w_gnt1) && !ow_mem_we;
            r_rd_id   <= w_gnt1;
        end
    end

    assign ow_gnt0    = w_gnt0;
    assign ow_gnt1    = w_gnt1;
    assign or_owner   = r_state;
    assign or_rvalid0 = r_rd_pend && !r_rd_id;
    assign or_rvalid1 = r_rd_pend && r_rd_id;
    assign ow_rdata0  = or_rvalid0 ? iw_mem_rdata : '0;
    assign ow_rdata1  = or_rvalid1 ? iw_mem_rdata : '0;

endmodule

// File: tb/tb_memarb.sv
// tb_memarb: directed scenarios plus randomized traffic for memarb, checked against a
// transaction-level reference model (owner/streak bookkeeping, reference memory, read-return slot).
module tb_memarb;

    localparam int SA = 8;
    localparam int SD = 16;
    localparam int MH = 4;

    logic          iw_clk;
    logic          iw_rst_n;
    logic          iw_req0, iw_req1, iw_we0, iw_we1;
    logic [SA-1:0] iw_addr0, iw_addr1;
    logic [SD-1:0] iw_wdata0, iw_wdata1;
    logic          ow_gnt0, ow_gnt1, or_rvalid0, or_rvalid1;
    logic [SD-1:0] ow_rdata0, ow_rdata1;
    logic          ow_mem_we;
    logic [SA-1:0] ow_mem_addr;
    logic [SD-1:0] ow_mem_wdata;
    logic [SD-1:0] iw_mem_rdata;
    logic [1:0]    or_owner;

    memarb #(.SIZE_ADDR(SA), .SIZE_DATA(SD), .MAX_HOLD(MH), .PRIO(1'b0)) dut (
        .iw_clk(iw_clk), .iw_rst_n(iw_rst_n),
        .iw_req0(iw_req0), .iw_req1(iw_req1), .iw_we0(iw_we0), .iw_we1(iw_we1),
        .iw_addr0(iw_addr0), .iw_addr1(iw_addr1), .iw_wdata0(iw_wdata0), .iw_wdata1(iw_wdata1),
        .ow_gnt0(ow_gnt0), .ow_gnt1(ow_gnt1), .or_rvalid0(or_rvalid0), .or_rvalid1(or_rvalid1),
        .ow_rdata0(ow_rdata0), .ow_rdata1(ow_rdata1), .ow_mem_we(ow_mem_we),
        .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata), .iw_mem_rdata(iw_mem_rdata),
        .or_owner(or_owner)
    );

    initial begin
        iw_clk = 1'b0;
        forever #5 iw_clk = ~iw_clk;
    end

    function automatic logic [SD-1:0] init_word(input logic [SA-1:0] a);
        return (a == 8'h10) ? 16'hABCD : ({a, ~a} ^ 16'h3C5A);
    endfunction

    // Environment memory: synchronous, one-cycle read latency, driven only by the DUT port.
    logic [SD-1:0] env_mem [256];
    bit            env_wr  [256];
    always @(posedge iw_clk) begin
        if (ow_mem_we) begin
            env_mem[ow_mem_addr] <= ow_mem_wdata;
            env_wr[ow_mem_addr]  <= 1'b1;
        end
        iw_mem_rdata <= env_wr[ow_mem_addr] ? env_mem[ow_mem_addr] : init_word(ow_mem_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [SD-1:0] ref_mem [256];
    int            m_owner;
    int            m_streak;
    bit            m_last;
    bit            m_pend;
    int            m_pend_id;
    logic [SD-1:0] m_pend_data;
    int            w0, w1;

    task automatic model_reset();
        m_owner  = -1;
        m_streak = 0;
        m_last   = 1'b1;
        m_pend   = 1'b0;
        w0       = 0;
        w1       = 0;
    endtask

    function automatic int model_grant(input bit r0, input bit r1);
        if (!r0 && !r1) return -1;
        if (!r1) return 0;
        if (!r0) return 1;
        if (m_owner < 0) return m_last ? 0 : 1;
        return (m_streak < MH) ? m_owner : 1 - m_owner;
    endfunction

    // Snapshot of the last sampled cycle, for scenario-specific checks.
    logic [1:0]    s_gnt, s_rv;
    logic [SA-1:0] s_addr;
    logic [SD-1:0] s_rd0;
    int            last_g;

    task automatic run_cycle(input bit rst_mid);
        int            g;
        logic [1:0]    eg, erv;
        logic          ewe;
        logic [SA-1:0] ea;
        logic [SD-1:0] ed, erd0, erd1;
        int            hold_exp;
        @(negedge iw_clk);
        if (!iw_rst_n) model_reset();
        g   = iw_rst_n ? model_grant(iw_req0, iw_req1) : -1;
        eg  = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        ewe = 1'b0; ea = '0; ed = '0;
        if (g == 0) begin ewe = iw_we0; ea = iw_addr0; ed = iw_wdata0; end
        if (g == 1) begin ewe = iw_we1; ea = iw_addr1; ed = iw_wdata1; end
        erv  = {m_pend && m_pend_id == 1, m_pend && m_pend_id == 0};
        erd0 = erv[0] ? m_pend_data : '0;
        erd1 = erv[1] ? m_pend_data : '0;
        hold_exp = (m_streak < MH) ? m_streak : MH;

        check_val("gnt", {30'd0, ow_gnt1, ow_gnt0}, {30'd0, eg});
        check_val("mem_we", {31'd0, ow_mem_we}, {31'd0, ewe});
        check_val("mem_addr", 32'(ow_mem_addr), 32'(ea));
        check_val("mem_wdata", 32'(ow_mem_wdata), 32'(ed));
        check_val("rvalid", {30'd0, or_rvalid1, or_rvalid0}, {30'd0, erv});
        check_val("rdata0", 32'(ow_rdata0), 32'(erd0));
        check_val("rdata1", 32'(ow_rdata1), 32'(erd1));
        check_val("owner", 32'(or_owner), (m_owner < 0) ? 32'd0 : 32'(m_owner + 1));
        check_val("hold", 32'(dut.r_hold), 32'(hold_exp));

        s_gnt  = {ow_gnt1, ow_gnt0};
        s_rv   = {or_rvalid1, or_rvalid0};
        s_addr = ow_mem_addr;
        s_rd0  = ow_rdata0;
        last_g = g;

        if (iw_rst_n) begin
            if (iw_req0) begin
                if (g == 0) begin check_val("wait0", 32'(w0 <= MH), 32'd1); w0 = 0; end
                else w0++;
            end
            if (iw_req1) begin
                if (g == 1) begin check_val("wait1", 32'(w1 <= MH), 32'd1); w1 = 0; end
                else w1++;
            end
            m_pend = 1'b0;
            if (g < 0) begin
                m_owner  = -1;
                m_streak = 0;
            end else begin
                m_streak = (g == m_owner) ? m_streak + 1 : 1;
                m_owner  = g;
                m_last   = (g == 1);
                if (!ewe) begin
                    m_pend      = 1'b1;
                    m_pend_id   = g;
                    m_pend_data = ref_mem[ea];
                end else begin
                    ref_mem[ea] = ed;
                end
            end
        end
        if (rst_mid) begin
            #2;
            iw_rst_n = 1'b0;
            model_reset();
        end
        @(posedge iw_clk);
        #1;
    endtask

    task automatic new_req(input int k);
        bit            r, w;
        logic [SA-1:0] a;
        logic [SD-1:0] d;
        r = ($urandom_range(0, 99) < 60);
        w = ($urandom_range(0, 9) < 4);
        a = SA'($urandom_range(0, 31));
        d = SD'($urandom);
        if (k == 0) begin iw_req0 = r; iw_we0 = w; iw_addr0 = a; iw_wdata0 = d; end
        else        begin iw_req1 = r; iw_we1 = w; iw_addr1 = a; iw_wdata1 = d; end
    endtask

    task automatic set_rd(input int k, input bit r, input logic [SA-1:0] a);
        if (k == 0) begin iw_req0 = r; iw_we0 = 1'b0; iw_addr0 = a; iw_wdata0 = '0; end
        else        begin iw_req1 = r; iw_we1 = 1'b0; iw_addr1 = a; iw_wdata1 = '0; end
    endtask

    logic [1:0] cont_seq [12];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(SA'(i));
        for (int i = 0; i < 12; i++) cont_seq[i] = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
        model_reset();

        // Reset held with both requests active, then contention from IDLE.
        iw_rst_n = 1'b0;
        set_rd(0, 1'b1, 8'h01);
        set_rd(1, 1'b1, 8'h02);
        @(posedge iw_clk); #1;
        for (int i = 0; i < 3; i++) run_cycle(1'b0);
        iw_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'b0);
            check_val("contention", 32'(s_gnt), 32'(cont_seq[i]));
            if (last_g >= 0) set_rd(last_g, 1'b1, SA'($urandom_range(0, 31)));
        end
        set_rd(0, 1'b0, 8'h00);
        run_cycle(1'b0);
        set_rd(1, 1'b0, 8'h00);
        run_cycle(1'b0);

        // Single read of 0x10.
        set_rd(0, 1'b1, 8'h10);
        run_cycle(1'b0);
        check_val("single_gnt", 32'(s_gnt), 32'd1);
        check_val("single_addr", 32'(s_addr), 32'h10);
        set_rd(0, 1'b0, 8'h00);
        run_cycle(1'b0);
        check_val("single_rvalid", 32'(s_rv), 32'd1);
        check_val("single_rdata", 32'(s_rd0), 32'hABCD);

        // Saturation: req1 alone for 10 cycles, then req0 joins.
        for (int i = 0; i < 10; i++) begin
            set_rd(1, 1'b1, SA'(i));
            run_cycle(1'b0);
            check_val("sat_gnt1", 32'(s_gnt), 32'd2);
        end
        set_rd(0, 1'b1, 8'h05);
        run_cycle(1'b0);
        check_val("sat_gnt0", 32'(s_gnt), 32'd1);
        set_rd(0, 1'b0, 8'h00);
        run_cycle(1'b0);
        set_rd(1, 1'b0, 8'h00);
        run_cycle(1'b0);

        // Round-robin from IDLE, both orders.
        for (int k = 1; k >= 0; k--) begin
            set_rd(k, 1'b1, 8'h03);
            run_cycle(1'b0);
            set_rd(k, 1'b0, 8'h00);
            run_cycle(1'b0);
            set_rd(0, 1'b1, 8'h04);
            set_rd(1, 1'b1, 8'h06);
            run_cycle(1'b0);
            check_val("rr_winner", 32'(s_gnt), (k == 1) ? 32'd1 : 32'd2);
            set_rd(1 - k, 1'b0, 8'h00);
            run_cycle(1'b0);
            set_rd(k, 1'b0, 8'h00);
            run_cycle(1'b0);
        end

        // Write then read-back through the other requester, then reset right after a read.
        iw_req1 = 1'b1; iw_we1 = 1'b1; iw_addr1 = 8'h20; iw_wdata1 = 16'h5A5A;
        run_cycle(1'b0);
        set_rd(1, 1'b0, 8'h00);
        set_rd(0, 1'b1, 8'h20);
        run_cycle(1'b0);
        set_rd(0, 1'b0, 8'h00);
        run_cycle(1'b0);
        check_val("wr_rd_rvalid", 32'(s_rv), 32'd1);
        check_val("wr_rd_rdata", 32'(s_rd0), 32'h5A5A);
        set_rd(0, 1'b1, 8'h10);
        run_cycle(1'b1);
        set_rd(0, 1'b0, 8'h00);
        run_cycle(1'b0);
        check_val("dropped_read", 32'(s_rv), 32'd0);
        iw_rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_cycle(1'b0);
            check_val("dropped_read", 32'(s_rv), 32'd0);
        end

        // Randomized traffic with occasional resets.
        new_req(0);
        new_req(1);
        for (int i = 0; i < 3000; i++) begin
            iw_rst_n = ($urandom_range(0, 199) != 0);
            run_cycle(1'b0);
            if (!iw_req0 || last_g == 0) new_req(0);
            if (!iw_req1 || last_g == 1) new_req(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
